// File: rtl/stage_memory.sv
// Memory stage of the pipeline: M latch, data-memory handshake with ack-wait stall, W latch.
// Optional MEM_TIMEOUT_EN adds a wait counter that aborts an unacknowledged access with a bus error.
module stage_memory #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              x_valid,
  input  logic [31:0]       x_insn,
  input  logic [31:0]       x_o,
  input  logic [31:0]       x_b,
  input  logic              x_exception,
  output logic              m_stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic [31:0]       w_insn,
  output logic [31:0]       w_o,
  output logic [31:0]       w_d,
  output logic              w_exception,
  output logic              w_valid
);

  localparam logic [4:0]  OP_LW   = 5'b01000;
  localparam logic [4:0]  OP_SW   = 5'b00111;
  localparam logic [31:0] BUS_ERR = 32'd6;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state, state_next;
  logic        m_valid, m_exc;
  logic [31:0] m_insn, m_o, m_b;
  logic        is_lw, is_sw, is_mem, timeout, complete;

  // M latch: frozen while the access is waiting for ack
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_insn  <= '0;
      m_o     <= '0;
      m_b     <= '0;
      m_exc   <= 1'b0;
    end else if (!m_stall) begin
      m_valid <= x_valid;
      m_insn  <= x_insn;
      m_o     <= x_o;
      m_b     <= x_b;
      m_exc   <= x_exception;
    end
  end

  assign is_lw      = m_valid & (m_insn[31:27] == OP_LW);
  assign is_sw      = m_valid & (m_insn[31:27] == OP_SW);
  assign is_mem     = is_lw | is_sw;
  assign dmem_req   = is_mem;
  assign dmem_we    = is_mem & is_sw;
  assign dmem_addr  = m_o[ADDR_W-1:0];
  assign dmem_wdata = m_b;
  assign m_stall    = is_mem & ~dmem_ack & ~timeout;
  assign complete   = m_valid & ~m_stall;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;

  // timeout fires on the TIMEOUT-th request cycle still lacking an ack
  assign timeout = is_mem & ~dmem_ack &
                   ((state == WAIT) ? (32'(wait_cnt) + 32'd2 == 32'(TIMEOUT))
                                    : (32'(TIMEOUT) == 32'd1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                   wait_cnt <= '0;
    else if (state == WAIT && state_next == WAIT) wait_cnt <= wait_cnt + CNT_W'(1);
    else                                         wait_cnt <= '0;
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign timeout        = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (dmem_req & ~dmem_ack & ~timeout) state_next = WAIT;
      WAIT:    if (dmem_ack | timeout)              state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (complete) state_next = IDLE;
  end

  // W latch: completed instruction, or a bubble when M stalls or is empty
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_valid     <= 1'b0;
      w_insn      <= '0;
      w_o         <= '0;
      w_d         <= '0;
      w_exception <= 1'b0;
    end else if (complete) begin
      w_valid     <= 1'b1;
      w_insn      <= m_insn;
      w_o         <= timeout ? BUS_ERR : m_o;
      w_d         <= timeout ? BUS_ERR : (is_lw ? dmem_rdata : 32'd0);
      w_exception <= timeout | m_exc;
    end else begin
      w_valid     <= 1'b0;
      w_insn      <= '0;
      w_o         <= '0;
      w_d         <= '0;
      w_exception <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stage_memory.sv
// Bench for stage_memory: directed instruction table with ack delays, a cycle-level reference model
// checked every falling edge, and literal expectations on the key scenarios.
module tb_stage_memory;

  localparam int unsigned AW  = 12;
  localparam int unsigned TMO = 4;
  localparam logic [31:0] LW_I  = 32'h4000_0012;
  localparam logic [31:0] SW_I  = 32'h3800_0034;
  localparam logic [31:0] ADD_I = 32'h0000_1234;
  localparam logic [31:0] OP9_I = 32'h4800_0056;
  localparam logic [31:0] OP6_I = 32'h3000_0001;

  logic          clock = 1'b0;
  logic          reset;
  logic          x_valid, x_exception, dmem_ack;
  logic [31:0]   x_insn, x_o, x_b, dmem_rdata;
  logic          m_stall, dmem_req, dmem_we, w_exception, w_valid;
  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_wdata, w_insn, w_o, w_d;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  stage_memory #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset),
    .x_valid(x_valid), .x_insn(x_insn), .x_o(x_o), .x_b(x_b), .x_exception(x_exception),
    .m_stall(m_stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .w_insn(w_insn), .w_o(w_o), .w_d(w_d), .w_exception(w_exception), .w_valid(w_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Reference model: slot contents plus how many cycles the current access has already requested
  logic        mv, mexc, ev, eexc;
  logic [31:0] minsn, mo, mb, einsn, eo, ed;
  int          reqcnt;

  initial begin
    mv = 0; mexc = 0; minsn = 0; mo = 0; mb = 0; reqcnt = 0;
    ev = 0; eexc = 0; einsn = 0; eo = 0; ed = 0;
  end

  always @(negedge clock) begin
    logic lw, sw, mem, tmo, stall, done;
    if (reset) begin
      chk("rst_req", 32'(dmem_req), 0);
      chk("rst_stall", 32'(m_stall), 0);
      chk("rst_wvalid", 32'(w_valid), 0);
      chk("rst_wo", w_o, 0);
      mv = 0; mexc = 0; minsn = 0; mo = 0; mb = 0; reqcnt = 0;
      ev = 0; eexc = 0; einsn = 0; eo = 0; ed = 0;
    end else begin
      chk("m_w_valid", 32'(w_valid), 32'(ev));
      chk("m_w_insn", w_insn, einsn);
      chk("m_w_o", w_o, eo);
      chk("m_w_d", w_d, ed);
      chk("m_w_exc", 32'(w_exception), 32'(eexc));
      lw  = mv && minsn[31:27] == 5'd8;
      sw  = mv && minsn[31:27] == 5'd7;
      mem = lw || sw;
`ifdef MEM_TIMEOUT_EN
      tmo = mem && !dmem_ack && (reqcnt + 1 == int'(TMO));
`else
      tmo = 1'b0;
`endif
      stall = mem && !dmem_ack && !tmo;
      done  = mv && !stall;
      chk("m_req", 32'(dmem_req), 32'(mem));
      chk("m_we", 32'(dmem_we), 32'(sw));
      chk("m_addr", 32'(dmem_addr), mo % 4096);
      chk("m_wdata", dmem_wdata, mb);
      chk("m_stall", 32'(m_stall), 32'(stall));
      ev    = done;
      einsn = done ? minsn : 0;
      eo    = !done ? 0 : (tmo ? 6 : mo);
      ed    = !done ? 0 : (tmo ? 6 : (lw ? dmem_rdata : 0));
      eexc  = done && (tmo || mexc);
      reqcnt = (mem && !done) ? reqcnt + 1 : 0;
      if (!stall) begin
        mv = x_valid; minsn = x_insn; mo = x_o; mb = x_b; mexc = x_exception;
      end
    end
  end

  typedef struct {
    logic        v;
    logic [31:0] insn, o, b;
    logic        exc;
    int          wait_n;
    logic [31:0] rdata;
    logic        ev;
    logic [31:0] eo, ed;
    logic        eexc;
  } vec_t;

  localparam int N = 9;
  vec_t tab [N];

  task automatic set_x(input vec_t t);
    x_valid = t.v; x_insn = t.insn; x_o = t.o; x_b = t.b; x_exception = t.exc;
  endtask

  task automatic clear_x();
    x_valid = 0; x_insn = 0; x_o = 0; x_b = 0; x_exception = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    tab[0] = '{1, ADD_I, 32'h5,         0,          0, 0, 32'h1111_1111, 1, 32'h5,         0,             0};
    tab[1] = '{1, LW_I,  32'h10,        0,          0, 0, 32'hDEAD_BEEF, 1, 32'h10,        32'hDEAD_BEEF, 0};
    tab[2] = '{1, SW_I,  32'h20,        32'h1234,   0, 3, 32'h2222_2222, 1, 32'h20,        0,             0};
    tab[3] = '{1, OP9_I, 32'h7FFF_FFFF, 0,          1, 0, 32'h3333_3333, 1, 32'h7FFF_FFFF, 0,             1};
    tab[4] = '{1, LW_I,  32'h1FFF,      0,          0, 1, 32'hCAFE_F00D, 1, 32'h1FFF,      32'hCAFE_F00D, 0};
    tab[5] = '{0, LW_I,  32'h44,        0,          0, 0, 32'h4444_4444, 0, 0,             0,             0};
    tab[6] = '{1, SW_I,  32'h30,        32'hA5A5,   1, 0, 32'h5555_5555, 1, 32'h30,        0,             1};
    tab[7] = '{1, OP6_I, 32'h9,         0,          0, 0, 32'h6666_6666, 1, 32'h9,         0,             0};
    tab[8] = '{1, LW_I,  32'h8,         0,          0, 2, 32'h0BAD_CAFE, 1, 32'h8,         32'h0BAD_CAFE, 0};

    reset = 1; clear_x(); dmem_ack = 0; dmem_rdata = 0;
    #2;
    chk("reset_wvalid", 32'(w_valid), 0);
    chk("reset_req", 32'(dmem_req), 0);
    tick(); tick();
    reset = 0;

    // Table run: the next entry waits in X while the current one sits in M
    set_x(tab[0]); dmem_ack = 0; tick();
    for (int i = 0; i < N; i++) begin
      if (i + 1 < N) set_x(tab[i + 1]); else clear_x();
      for (int j = 0; j < tab[i].wait_n; j++) begin
        dmem_ack = 0; dmem_rdata = 32'hBAD0_0000 + 32'(j);
        if (i == 2) begin
          #1;
          chk("sw_wait_stall", 32'(m_stall), 1);
          chk("sw_wait_we", 32'(dmem_we), 1);
          chk("sw_wait_addr", 32'(dmem_addr), 32'h20);
          chk("sw_wait_wdata", dmem_wdata, 32'h1234);
          if (j > 0) chk("sw_wait_wbubble", 32'(w_valid), 0);
        end
        tick();
      end
      dmem_ack = 1; dmem_rdata = tab[i].rdata;
      #1;
      if (i == 1) chk("lw_no_stall", 32'(m_stall), 0);
      if (i == 2) chk("sw_ack_we", 32'(dmem_we), 1);
      tick();
      chk("tab_w_valid", 32'(w_valid), 32'(tab[i].ev));
      chk("tab_w_insn", w_insn, tab[i].ev ? tab[i].insn : 32'd0);
      chk("tab_w_o", w_o, tab[i].eo);
      chk("tab_w_d", w_d, tab[i].ed);
      chk("tab_w_exc", 32'(w_exception), 32'(tab[i].eexc));
    end
    dmem_ack = 0; dmem_rdata = 0;
    tick();

`ifdef MEM_TIMEOUT_EN
    // Unanswered load: four request cycles, then a bus-error writeback
    x_valid = 1; x_insn = LW_I; x_o = 32'h40; tick();
    clear_x();
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("tmo_req", 32'(dmem_req), 1);
      chk("tmo_stall", 32'(m_stall), (j < 3) ? 32'd1 : 32'd0);
      tick();
    end
    chk("tmo_w_valid", 32'(w_valid), 1);
    chk("tmo_w_exc", 32'(w_exception), 1);
    chk("tmo_w_o", w_o, 6);
    chk("tmo_w_d", w_d, 6);
    chk("tmo_req_drop", 32'(dmem_req), 0);
    tick();
`endif

    // Reset while a load is waiting for ack
    x_valid = 1; x_insn = LW_I; x_o = 32'h55; tick();
    clear_x(); tick();
    chk("pre_rst_req", 32'(dmem_req), 1);
    #1 reset = 1;
    #1;
    chk("mid_rst_req", 32'(dmem_req), 0);
    chk("mid_rst_stall", 32'(m_stall), 0);
    chk("mid_rst_wvalid", 32'(w_valid), 0);
    tick();
    reset = 0;
    x_valid = 1; x_insn = ADD_I; x_o = 32'h77; tick();
    clear_x(); tick();
    chk("post_rst_wvalid", 32'(w_valid), 1);
    chk("post_rst_wo", w_o, 32'h77);
    chk("post_rst_winsn", w_insn, ADD_I);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stage_memory.md
STAGE_MEMORY -- requirements
Module: stage_memory

Interface
REQ-001 Parameter ADDR_W, default 12: data-memory word-address width.
REQ-002 Parameter TIMEOUT, default 16: max dmem_req cycles per access before bus-error abort.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 x_valid  input  1  X/M slot holds a real instruction.
REQ-006 x_insn  input  32  instruction from execute.
REQ-007 x_o  input  32  ALU result / effective address.
REQ-008 x_b  input  32  store data (rd value).
REQ-009 x_exception  input  1  execute-stage overflow flag.
REQ-010 m_stall  output  1  freeze execute and earlier stages this cycle.
REQ-011 dmem_req  output  1  memory access request.
REQ-012 dmem_we  output  1  write strobe, valid only with dmem_req.
REQ-013 dmem_addr  output  ADDR_W  word address.
REQ-014 dmem_wdata  output  32  store data.
REQ-015 dmem_ack  input  1  access complete this cycle; rdata valid.
REQ-016 dmem_rdata  input  32  load data.
REQ-017 w_insn, w_o, w_d  output  32 each  insn, ALU result, load data to writeback.
REQ-018 w_exception  output  1  writeback redirects rd to $r30.
REQ-019 w_valid  output  1  W slot holds a real instruction.

Function
REQ-020 M latch (m_valid, m_insn, m_o, m_b, m_exc) SHALL load x_* every edge with m_stall=0 and hold while m_stall=1.
REQ-021 is_mem SHALL be m_valid & (opcode m_insn[31:27] = 01000 lw or 00111 sw).
REQ-022 dmem_req = is_mem; dmem_we = dmem_req & sw; dmem_addr = m_o[ADDR_W-1:0]; dmem_wdata = m_b; all combinational from M latch.
REQ-023 FSM states IDLE, WAIT; IDLE->WAIT when dmem_req & ~dmem_ack & ~timeout; WAIT->IDLE on dmem_ack or timeout; any state ->IDLE when M slot completes.
REQ-024 Wait counter SHALL clear in IDLE, increment each WAIT cycle; timeout asserts when dmem_req has been high TIMEOUT cycles (counter = TIMEOUT-2 in WAIT, or TIMEOUT=1 in IDLE) without ack.
REQ-025 m_stall = is_mem & ~dmem_ack & ~timeout, combinational.
REQ-026 M completes when m_valid & ~m_stall: W latch loads w_valid=1, w_insn=m_insn, w_o=m_o, w_d=(lw ? dmem_rdata : 0), w_exception=m_exc.
REQ-027 On timeout completion w_exception=1, w_o=w_d=32'd6 (bus-error status); stores are dropped.
REQ-028 When M does not complete (stall or m_valid=0), W latch SHALL load bubble: w_valid=0, w_insn=0, w_o=w_d=0, w_exception=0.
REQ-029 Non-memory instruction latency X->W = 2 edges; lw/sw with same-cycle ack also 2; each ack-wait cycle adds 1.
REQ-030 dmem_ack while dmem_req=0 SHALL be ignored.
REQ-031 x_valid=0 SHALL load bubble into M; bubbles never raise dmem_req.

Reset
REQ-032 reset SHALL asynchronously clear M and W latches to 0, FSM to IDLE, counter to 0; all outputs 0 while reset high.
REQ-033 reset mid-access SHALL drop dmem_req in the same cycle; the aborted instruction never reaches W.

Configuration
REQ-034 Macro MEM_TIMEOUT_EN: defined -> counter and timeout abort per REQ-024/027; undefined -> no counter, timeout tied 0, stall persists until dmem_ack; TIMEOUT unused.

Verification
REQ-035 add insn, x_o=0x5 -> two edges later w_valid=1, w_o=0x5, w_d=0, dmem_req never high.
REQ-036 lw x_o=0x10, ack same cycle, rdata=0xDEADBEEF -> no stall, w_d=0xDEADBEEF next edge.
REQ-037 sw x_o=0x20, x_b=0x1234, ack after 3 cycles -> dmem_we=1, addr 0x20, wdata 0x1234 for 4 cycles, m_stall high 3 cycles, 3 W bubbles, then sw in W.
REQ-038 MEM_TIMEOUT_EN, TIMEOUT=4, lw, never ack -> dmem_req high 4 cycles, then w_exception=1, w_o=w_d=6.
REQ-039 reset asserted during WAIT -> dmem_req, m_stall, w_valid 0 immediately; after release next valid insn processed normally.
